// File: rtl/conv_mac_pipe.sv
// Pipelined convolution MAC: per-tap products, registered binary adder tree,
// multi-channel accumulation and saturated output, all under one global stall.
module conv_mac_pipe #(
  parameter int unsigned DATA_W = 6,
  parameter int unsigned K_TAPS = 25,
  parameter int unsigned CH     = 1,
  parameter int unsigned SIGNED = 0,
  parameter int unsigned OUT_W  = 18
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [K_TAPS*DATA_W-1:0]   in_data,
  input  logic [K_TAPS*DATA_W-1:0]   kernel,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           out_data,
  output logic                       out_sat
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned D      = $clog2(K_TAPS);
  localparam int unsigned TREE_W = PROD_W + D;
  localparam int unsigned ACC_W  = TREE_W + $clog2(CH) + 1;
  // One spare bit so unsigned values stay non-negative in a signed container.
  localparam int unsigned EXT_W  = ACC_W + 1;
  localparam int unsigned CMP_W  = ((EXT_W > OUT_W + 1) ? EXT_W : OUT_W + 1) + 1;
  localparam int unsigned CNT_W  = (CH > 1) ? $clog2(CH) : 1;

  localparam logic signed [CMP_W-1:0] UMAX = {{(CMP_W - OUT_W){1'b0}}, {OUT_W{1'b1}}};
  localparam logic signed [CMP_W-1:0] SMAX = {{(CMP_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [CMP_W-1:0] SMIN = {{(CMP_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

  typedef logic signed [EXT_W-1:0] val_t;

  function automatic val_t ext(input logic [DATA_W-1:0] x);
    if (SIGNED != 0) begin
      return val_t'($signed(x));
    end
    return val_t'(x);
  endfunction

  // Number of live elements at a given tree level (level 0 = products).
  function automatic int unsigned lvl_cnt(input int unsigned l);
    int unsigned n;
    n = K_TAPS;
    for (int unsigned i = 0; i < l; i++) begin
      n = (n + 1) / 2;
    end
    return n;
  endfunction

  logic                 adv;
  val_t                 lvl_q [D+1][K_TAPS];
  logic [D:0]           vld_q;
  val_t                 acc_q;
  val_t                 acc_nxt;
  logic                 done_q;
  logic                 last_beat;
  logic [CNT_W-1:0]     ch_cnt_q;
  logic                 out_valid_q;
  logic [OUT_W-1:0]     out_data_q;
  logic                 out_sat_q;
  logic signed [CMP_W-1:0] acc_ext;
  logic signed [CMP_W-1:0] sat_val;
  logic                 sat_flag;

  assign adv       = !out_valid_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

  always_comb begin
    last_beat = (ch_cnt_q == CNT_W'(CH - 1));
    acc_nxt   = (ch_cnt_q == '0) ? lvl_q[D][0] : acc_q + lvl_q[D][0];
  end

  always_comb begin
    acc_ext  = CMP_W'(acc_q);
    sat_val  = acc_ext;
    sat_flag = 1'b0;
    if (SIGNED != 0) begin
      if (acc_ext > SMAX) begin
        sat_val  = SMAX;
        sat_flag = 1'b1;
      end else if (acc_ext < SMIN) begin
        sat_val  = SMIN;
        sat_flag = 1'b1;
      end
    end else if (acc_ext > UMAX) begin
      sat_val  = UMAX;
      sat_flag = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q       <= '0;
      acc_q       <= '0;
      done_q      <= 1'b0;
      ch_cnt_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      for (int unsigned l = 0; l <= D; l++) begin
        for (int unsigned j = 0; j < K_TAPS; j++) begin
          lvl_q[l][j] <= '0;
        end
      end
    end else if (adv) begin
      vld_q <= {vld_q[D-1:0], in_valid};
      for (int unsigned i = 0; i < K_TAPS; i++) begin
        lvl_q[0][i] <= ext(in_data[i*DATA_W +: DATA_W]) * ext(kernel[i*DATA_W +: DATA_W]);
      end
      // Pairwise reduction; an odd tail element is carried forward unchanged.
      for (int unsigned l = 1; l <= D; l++) begin
        for (int unsigned j = 0; j < K_TAPS; j++) begin
          if (2 * j + 1 < lvl_cnt(l - 1)) begin
            lvl_q[l][j] <= lvl_q[l-1][2*j] + lvl_q[l-1][2*j+1];
          end else if (2 * j < lvl_cnt(l - 1)) begin
            lvl_q[l][j] <= lvl_q[l-1][2*j];
          end else begin
            lvl_q[l][j] <= '0;
          end
        end
      end

      done_q <= 1'b0;
      if (vld_q[D]) begin
        acc_q    <= acc_nxt;
        done_q   <= last_beat;
        ch_cnt_q <= last_beat ? '0 : ch_cnt_q + CNT_W'(1);
      end

      out_valid_q <= done_q;
      if (done_q) begin
        out_data_q <= sat_val[OUT_W-1:0];
        out_sat_q  <= sat_flag;
      end
    end
  end

endmodule
